spi_frame_slave: RTL
====================

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

Interface
REQ-001 Parameter ADDR_BYTES, default 2, number of address bytes per frame (1..4); ADDR width AW = 8*ADDR_BYTES.
REQ-002 Parameter CPOL, default 0, SCLK idle level.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter AUTO_INC, default 1; 1 = ADDR increments after each data byte.
REQ-005 clk  in  1  master clock; the block has one clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 SCLK  in  1  SPI clock, asynchronous, at most clk/8.
REQ-008 SS  in  1  slave select, active low, asynchronous.
REQ-009 MOSI  in  1  serial data in, MSB first.
REQ-010 MISO  out  1  serial data out, MSB first.
REQ-011 STA  in  8  status byte, shifted out during the CMD byte.
REQ-012 DATA_in  in  8  read data, sampled on the clk cycle after data_req.
REQ-013 CMD  out  8  command byte, held until the next frame.
REQ-014 ADDR  out  AW  current address, MSB byte received first.
REQ-015 DATA_out  out  8  last received data byte.
REQ-016 RAW_out  out  8  last received byte of any phase.
REQ-017 cmd_valid / addr_valid / data_valid  out  1 each  one-cycle pulses.
REQ-018 data_req  out  1  one-cycle pulse requesting DATA_in for the next byte.
REQ-019 err_in  in  1  abort request from the controller.
REQ-020 err_out  out  1  sticky frame error.
REQ-021 EoB  out  1  one-cycle end-of-byte pulse.
REQ-022 busy  out  1  high while SS is low.

Function
REQ-023 SCLK, SS and MOSI pass through 2-FF synchronisers; SCLK and SS edges are detected in the clk domain.
REQ-024 The sample edge and the shift edge are set by CPOL/CPHA per the standard SPI modes 0-3.
REQ-025 The FSM has states IDLE, CMD, ADDR, DATA, ABORT.
REQ-026 Transitions:
- IDLE->CMD on SS falling edge; this clears the bit counter, byte counter and err_out.
- CMD->ADDR after 8 bits.
- ADDR->DATA after ADDR_BYTES bytes.
- DATA stays in DATA for an unlimited burst.
- Any state->IDLE on SS rising edge.
REQ-027 Every completed byte pulses EoB and updates RAW_out on the same cycle.
REQ-028 End of CMD byte: load CMD, pulse cmd_valid, pulse data_req.
REQ-029 End of last ADDR byte: pulse addr_valid, pulse data_req.
REQ-030 End of each DATA byte:
- load DATA_out and pulse data_valid, with ADDR still holding that byte's address;
- one cycle later, if AUTO_INC=1, increment ADDR modulo 2^AW (all-ones wraps to 0);
- pulse data_req.
REQ-031 MISO shift register contents per phase:
- CMD byte: STA, loaded on the SS falling edge.
- ADDR bytes: 0x00.
- DATA bytes: the DATA_in captured after the preceding data_req.
REQ-032 MISO is 0 while SS is high.
REQ-033 If SS rises with the bit counter nonzero, err_out sets; an incomplete byte produces no valid pulse and no EoB.
REQ-034 err_in=1 while busy causes a transition to ABORT:
- err_out sets;
- MISO outputs 1 for the rest of the frame;
- no further valid or req pulses are issued;
- the FSM leaves ABORT only on the SS rising edge.
REQ-035 err_in while IDLE is ignored.
REQ-036 An SS falling edge coincident with err_in starts the frame, and that frame then aborts.

Reset
REQ-037 On rst, regardless of SS:
- FSM goes to IDLE;
- CMD, ADDR, DATA_out, RAW_out, counters and the shift register clear to 0;
- MISO=0, err_out=0, busy=0, all pulses 0.
REQ-038 A frame in progress at reset is discarded; the block resumes only on the next SS falling edge after rst deasserts.

Structure
REQ-039 A shared package holds the FSM state encoding, the mode constants MODE0..MODE3 and the STA_IDLE byte (8'h00).
REQ-040 A sub-module spi_sync_edge implements the 2-FF synchroniser with rise/fall pulse outputs; it is instantiated for SCLK and SS.

Verification
REQ-041 Mode 0, ADDR_BYTES=2: frame 0x02,0x12,0x34,0xAA,0xBB with STA=0x5A and DATA_in=0xC3 -> MISO returns 0x5A,0x00,0x00,0xC3,0xC3; outputs:
- CMD=0x02;
- addr_valid with ADDR=0x1234;
- data_valid with DATA_out=0xAA at ADDR 0x1234, then 0xBB at ADDR 0x1235.
REQ-042 Mode 3 (CPOL=1, CPHA=1): same frame as REQ-041 -> identical CMD/ADDR/DATA_out results.
REQ-043 ADDR_BYTES=1, address 0xFF, 3 data bytes -> data bytes written at ADDR 0xFF, 0x00, 0x01.
REQ-044 SS raised after 5 bits of the 2nd data byte -> err_out=1, exactly one data_valid, FSM IDLE; err_out clears on the next SS falling edge.
REQ-045 err_in pulse during the ADDR phase -> MISO=1 until SS rises, no addr_valid, err_out=1.
REQ-046 rst asserted mid-DATA with SS held low -> all outputs 0; the next byte is ignored until SS toggles.

Source files
------------

// File: rtl/spi_frame_slave_pkg.sv
// Shared definitions for the SPI frame slave: FSM encoding, SPI mode constants
// and the filler byte returned while the address is being received.
package spi_frame_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  localparam logic [7:0] STA_IDLE = 8'h00;

  // Modes 0 and 3 sample MOSI on the rising SCLK edge, modes 1 and 2 on the falling one.
  function automatic logic sample_on_rise(input logic [1:0] mode);
    case (mode)
      MODE0, MODE3: return 1'b1;
      MODE1, MODE2: return 1'b0;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, plus single-cycle rise/fall pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Unreset on purpose: the chain always tracks the pin, so an input held
  // steady through reset produces no spurious edge afterwards.
  always_ff @(posedge clk) begin
    s1 <= d;
    s2 <= s1;
    s3 <= s2;
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI slave that splits each SS-framed transfer into a command byte, an address
// field and an unbounded burst of data bytes.
//   state | meaning
//   IDLE  | no frame; waiting for SS falling edge
//   CMD   | receiving the command byte, STA shifting out
//   ADDR  | receiving ADDR_BYTES address bytes, zeros shifting out
//   DATA  | burst of data bytes, DATA_in shifting out
//   ABORT | frame aborted by err_in; MISO held high until SS rises
module spi_frame_slave
  import spi_frame_slave_pkg::*;
#(
  parameter int ADDR_BYTES = 2,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int AUTO_INC   = 1,
  localparam int AW        = 8 * ADDR_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          SCLK,
  input  logic          SS,
  input  logic          MOSI,
  output logic          MISO,
  input  logic [7:0]    STA,
  input  logic [7:0]    DATA_in,
  output logic [7:0]    CMD,
  output logic [AW-1:0] ADDR,
  output logic [7:0]    DATA_out,
  output logic [7:0]    RAW_out,
  output logic          cmd_valid,
  output logic          addr_valid,
  output logic          data_valid,
  output logic          data_req,
  input  logic          err_in,
  output logic          err_out,
  output logic          EoB,
  output logic          busy
);

  localparam logic [1:0] MODE        = 2'(CPOL * 2 + CPHA);
  localparam logic       SAMPLE_RISE = sample_on_rise(MODE);

  state_t     state, state_nxt;
  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic       mosi_m, mosi_s;
  logic [2:0] bit_cnt, byte_cnt;
  logic [7:0] rx_sreg, tx_sreg, rx_byte;
  logic       ld_pend, inc_pend;
  logic       sample_edge, shift_edge, active, byte_done, last_addr;

  spi_sync_edge u_sclk (.clk(clk), .d(SCLK), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_ss   (.clk(clk), .d(SS),   .rise(ss_rise),   .fall(ss_fall));

  always_ff @(posedge clk) begin
    mosi_m <= MOSI;
    mosi_s <= mosi_m;
  end

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  assign active      = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
  assign rx_byte     = {rx_sreg[6:0], mosi_s};
  assign byte_done   = active && sample_edge && (bit_cnt == 3'd7) && !err_in && !ss_rise;
  assign last_addr   = (byte_cnt == 3'(ADDR_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:           if (ss_fall) state_nxt = err_in ? ST_ABORT : ST_CMD;
      ST_CMD:            if (byte_done) state_nxt = ST_ADDR;
      ST_ADDR:           if (byte_done && last_addr) state_nxt = ST_DATA;
      ST_DATA, ST_ABORT: state_nxt = state;
      default:           state_nxt = ST_IDLE;
    endcase
    if (active && err_in) state_nxt = ST_ABORT;
    if (ss_rise)          state_nxt = ST_IDLE;
  end

  always_comb begin
    busy = (state != ST_IDLE);
    case (state)
      ST_IDLE:  MISO = 1'b0;
      ST_ABORT: MISO = 1'b1;
      default:  MISO = tx_sreg[7];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_sreg    <= '0;
      tx_sreg    <= '0;
      CMD        <= '0;
      ADDR       <= '0;
      DATA_out   <= '0;
      RAW_out    <= '0;
      err_out    <= 1'b0;
      cmd_valid  <= 1'b0;
      addr_valid <= 1'b0;
      data_valid <= 1'b0;
      data_req   <= 1'b0;
      EoB        <= 1'b0;
      ld_pend    <= 1'b0;
      inc_pend   <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      addr_valid <= 1'b0;
      data_valid <= 1'b0;
      data_req   <= 1'b0;
      EoB        <= 1'b0;
      ld_pend    <= data_req;
      inc_pend   <= data_valid;

      if (state == ST_IDLE && ss_fall) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        err_out  <= err_in;
        tx_sreg  <= STA;
      end
      if (active && err_in) err_out <= 1'b1;
      if (ss_rise && state != ST_IDLE && bit_cnt != 3'd0) err_out <= 1'b1;

      if (active && sample_edge && !err_in) begin
        rx_sreg <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      // No shift on the first shift edge of a byte: the MSB is already on MISO.
      if (active && shift_edge && bit_cnt != 3'd0) tx_sreg <= {tx_sreg[6:0], 1'b0};
      if (ld_pend && state == ST_DATA) tx_sreg <= DATA_in;
      if (inc_pend && AUTO_INC != 0) ADDR <= ADDR + AW'(1);

      if (byte_done) begin
        EoB      <= 1'b1;
        RAW_out  <= rx_byte;
        data_req <= 1'b1;
        case (state)
          ST_CMD: begin
            CMD       <= rx_byte;
            cmd_valid <= 1'b1;
            tx_sreg   <= STA_IDLE;
          end
          ST_ADDR: begin
            ADDR     <= (ADDR << 8) | AW'(rx_byte);
            byte_cnt <= byte_cnt + 3'd1;
            if (last_addr) addr_valid <= 1'b1;
            else           tx_sreg    <= STA_IDLE;
          end
          ST_DATA: begin
            DATA_out   <= rx_byte;
            data_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
